// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the instruction-memory read handshake, the redirect input and the
//   IF/ID output handshake of the kanade32 fetch stage.
//   master : the fetch unit (drives imem_req/imem_addr and out_*).
//   slave  : the environment (memory, EX/MEM redirect source, IF/ID register).
// Signals
//   imem_req/imem_addr   read request and its word address
//   imem_ack/imem_rdata  request accepted, instruction word valid same cycle
//   redirect/redirect_pc one-cycle flush-and-restart pulse and its target
//   out_valid/out_ready  IF/ID handshake
//   out_ins/out_next_pc  head instruction and its fetch address + 4
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_next_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output out_valid, out_ins, out_next_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  out_valid, out_ins, out_next_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage of the kanade32 pipeline. Owns the fetch PC,
//   issues word reads to instruction memory, buffers the returned words in a
//   small prefetch FIFO and presents {ins, next_pc} to IF/ID. A redirect
//   flushes the FIFO and discards any read still in flight.
// Parameters
//   RESET_PC  fetch PC after reset (word aligned)
//   DEPTH     prefetch FIFO entries (power of 2, >= 2)
// Ports
//   clk       clock, all state changes on posedge
//   reset_n   synchronous active-low reset
//   bus       fetch_unit_if.master (memory, redirect and IF/ID handshakes)
//   stat_fetched / stat_flushed  statistics counters, only when the
//                                FETCH_STATS_EN macro is defined
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DROP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      ins_mem_q [DEPTH];
  logic [31:0]      ins_mem_d [DEPTH];
  logic [31:0]      npc_mem_q [DEPTH];
  logic [31:0]      npc_mem_d [DEPTH];

  logic        out_valid;
  logic        push;
  logic        pop;
  logic        discard;
  logic        have_space;
  logic [31:0] addr_plus4;
  logic [31:0] redirect_pc_al;

  assign addr_plus4     = addr_q + 32'd4;
  assign redirect_pc_al = bus.redirect_pc & ~32'h3;
  assign out_valid      = (count_q != '0);

  // Redirect wins over both push and pop; an acked word is only kept when the
  // request is still live (REQ) and no redirect arrives in the same cycle.
  assign push    = (state_q == ST_REQ) && bus.imem_ack && !bus.redirect;
  assign pop     = out_valid && bus.out_ready && !bus.redirect;
  assign discard = bus.imem_ack &&
                   (((state_q == ST_REQ) && bus.redirect) || (state_q == ST_DROP));

  // Space is judged on the occupancy after this cycle's push/pop, so the
  // request about to be issued always has a slot reserved for its word.
  assign have_space = (count_d < CNT_W'(DEPTH));

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ins_mem_d = ins_mem_q;
    npc_mem_d = npc_mem_q;
    if (push) begin
      ins_mem_d[wr_ptr_q] = bus.imem_rdata;
      npc_mem_d[wr_ptr_q] = addr_plus4;
    end
  end

  // DROP keeps the abandoned request on the bus until memory acks it, so the
  // handshake is never cut short; its data is thrown away.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = redirect_pc_al;
        end else if (have_space) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = bus.imem_ack ? ST_IDLE : ST_DROP;
        end else if (bus.imem_ack) begin
          fetch_pc_d = addr_plus4;
          if (have_space) begin
            addr_d = addr_plus4;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (bus.redirect) fetch_pc_d = redirect_pc_al;
        if (bus.imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q
  // covers them.
  always_ff @(posedge clk) begin
    ins_mem_q <= ins_mem_d;
    npc_mem_q <= npc_mem_d;
  end

  assign bus.imem_req    = (state_q != ST_IDLE);
  assign bus.imem_addr   = addr_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_ins     = out_valid ? ins_mem_q[rd_ptr_q] : 32'h0;
  assign bus.out_next_pc = out_valid ? npc_mem_q[rd_ptr_q] : 32'h0;

  no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (count_q == CNT_W'(DEPTH))));

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;

  // Flushed counts both buffered entries lost to a redirect and words that
  // came back from memory only to be thrown away.
  always_comb begin
    stat_fetched_d = stat_fetched_q + {31'b0, push};
    stat_flushed_d = stat_flushed_q;
    if (bus.redirect) stat_flushed_d = stat_flushed_d + 32'(count_q);
    if (discard)      stat_flushed_d = stat_flushed_d + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with a directed prologue followed by randomized memory
//   latency, IF/ID back-pressure, redirects and resets. A transaction-level
//   model (a queue of buffered words plus one outstanding-request record)
//   predicts every output each cycle.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic clk;
  logic reset_n;

  fetch_unit_if bus();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] npc;
  } entry_t;

  // Model state: buffered words, fetch PC, and the single outstanding read.
  entry_t      m_fifo[$];
  logic [31:0] m_fetch_pc;
  bit          m_req_active;
  bit          m_req_drop;
  logic [31:0] m_req_addr;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;
  bit          model_valid;

  int checks;
  int failures;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's prediction.
  task automatic checkOutput();
    bit          e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_npc;
    if (!model_valid) return;
    e_valid = (m_fifo.size() != 0);
    e_ins   = e_valid ? m_fifo[0].ins : 32'h0;
    e_npc   = e_valid ? m_fifo[0].npc : 32'h0;
    checkValue("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req_active});
    if (m_req_active) checkValue("imem_addr", bus.imem_addr, m_req_addr);
    checkValue("out_valid", {31'b0, bus.out_valid}, {31'b0, e_valid});
    checkValue("out_ins", bus.out_ins, e_ins);
    checkValue("out_next_pc", bus.out_next_pc, e_npc);
`ifdef FETCH_STATS_EN
    checkValue("stat_fetched", stat_fetched, m_fetched);
    checkValue("stat_flushed", stat_flushed, m_flushed);
`endif
  endtask

  // Advance the model by one clock edge using the inputs the bench drove.
  task automatic modelStep();
    bit was_active;
    bit completed_live;
    bit pop;
    if (!reset_n) begin
      m_fifo.delete();
      m_fetch_pc   = 32'h0;
      m_req_active = 1'b0;
      m_req_drop   = 1'b0;
      m_req_addr   = 32'h0;
      m_fetched    = 32'h0;
      m_flushed    = 32'h0;
      model_valid  = 1'b1;
      return;
    end
    was_active     = m_req_active;
    completed_live = m_req_active && !m_req_drop && bus.imem_ack && !bus.redirect;
    pop            = (m_fifo.size() != 0) && bus.out_ready && !bus.redirect;
    if (bus.redirect) begin
      m_flushed  = m_flushed + 32'(m_fifo.size());
      m_fifo.delete();
      m_fetch_pc = bus.redirect_pc & ~32'h3;
      if (m_req_active) begin
        if (bus.imem_ack) begin
          m_flushed    = m_flushed + 32'd1;
          m_req_active = 1'b0;
          m_req_drop   = 1'b0;
        end else begin
          m_req_drop = 1'b1;
        end
      end
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (m_req_active && bus.imem_ack) begin
        if (m_req_drop) begin
          m_flushed    = m_flushed + 32'd1;
          m_req_active = 1'b0;
          m_req_drop   = 1'b0;
        end else begin
          m_fifo.push_back('{ins: bus.imem_rdata, npc: m_req_addr + 32'd4});
          m_fetched    = m_fetched + 32'd1;
          m_fetch_pc   = m_req_addr + 32'd4;
          m_req_active = 1'b0;
        end
      end
    end
    if (!bus.redirect && (m_fifo.size() < DEPTH) && (!was_active || completed_live)) begin
      m_req_active = 1'b1;
      m_req_drop   = 1'b0;
      m_req_addr   = m_fetch_pc;
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, model at posedge.
  task automatic applyStimulus(input bit rst_n_i, input bit ack_i, input logic [31:0] rdata_i,
                               input bit redir_i, input logic [31:0] rpc_i, input bit ready_i);
    reset_n         = rst_n_i;
    bus.imem_ack    = ack_i;
    bus.imem_rdata  = rdata_i;
    bus.redirect    = redir_i;
    bus.redirect_pc = rpc_i;
    bus.out_ready   = ready_i;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    m_req_active = 1'b0;
    m_req_drop   = 1'b0;
    m_req_addr   = 32'h0;
    m_fetch_pc   = 32'h0;
    m_fetched    = 32'h0;
    m_flushed    = 32'h0;

    // Reset
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkValue("rst_req", {31'b0, bus.imem_req}, 32'h0);
    checkValue("rst_addr", bus.imem_addr, 32'h0);
    checkValue("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    checkValue("rst_ins", bus.out_ins, 32'h0);
    checkValue("rst_npc", bus.out_next_pc, 32'h0);

    // First request one cycle after release, then one word per cycle
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("first_req", {31'b0, bus.imem_req}, 32'h1);
    checkValue("first_addr", bus.imem_addr, 32'h0);
    applyStimulus(1, 1, 32'h1111_0000, 0, 32'h0, 1);
    checkValue("stream_addr1", bus.imem_addr, 32'h4);
    checkValue("stream_ins1", bus.out_ins, 32'h1111_0000);
    checkValue("stream_npc1", bus.out_next_pc, 32'h4);
    applyStimulus(1, 1, 32'h2222_0000, 0, 32'h0, 1);
    checkValue("stream_addr2", bus.imem_addr, 32'h8);
    checkValue("stream_ins2", bus.out_ins, 32'h2222_0000);
    checkValue("stream_npc2", bus.out_next_pc, 32'h8);

    // Back-pressure: FIFO fills, requests stop, then resume
    applyStimulus(1, 1, 32'h3333_0000, 0, 32'h0, 0);
    checkValue("full_req", {31'b0, bus.imem_req}, 32'h0);
    checkValue("full_npc", bus.out_next_pc, 32'h8);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("full_hold_req", {31'b0, bus.imem_req}, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("resume_req", {31'b0, bus.imem_req}, 32'h1);
    checkValue("resume_addr", bus.imem_addr, 32'hC);
    checkValue("resume_npc", bus.out_next_pc, 32'hC);

    // Slow memory at 0x10
    applyStimulus(1, 1, 32'h4444_0000, 0, 32'h0, 1);
    checkValue("slow_addr0", bus.imem_addr, 32'h10);
    checkValue("slow_ins0", bus.out_ins, 32'h4444_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
      checkValue("slow_req", {31'b0, bus.imem_req}, 32'h1);
      checkValue("slow_addr", bus.imem_addr, 32'h10);
    end
    checkValue("slow_empty", {31'b0, bus.out_valid}, 32'h0);
    applyStimulus(1, 1, 32'h5555_0000, 0, 32'h0, 1);
    checkValue("slow_ins", bus.out_ins, 32'h5555_0000);
    checkValue("slow_npc", bus.out_next_pc, 32'h14);

    // Redirect while a request is pending without ack
    applyStimulus(1, 0, 32'h0, 1, 32'h0000_0103, 1);
    checkValue("drop_req", {31'b0, bus.imem_req}, 32'h1);
    checkValue("drop_valid", {31'b0, bus.out_valid}, 32'h0);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
    checkValue("drop_done_req", {31'b0, bus.imem_req}, 32'h0);
    checkValue("drop_done_valid", {31'b0, bus.out_valid}, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("redir_addr", bus.imem_addr, 32'h100);
`ifdef FETCH_STATS_EN
    checkValue("lit_fetched", stat_fetched, 32'd5);
    checkValue("lit_flushed", stat_flushed, 32'd2);
`endif

    // Redirect with ack while one entry is held; target near the wrap point
    applyStimulus(1, 1, 32'h6666_0000, 0, 32'h0, 0);
    checkValue("held_npc", bus.out_next_pc, 32'h104);
    applyStimulus(1, 1, 32'h7777_0000, 1, 32'hFFFF_FFF8, 1);
    checkValue("rack_valid", {31'b0, bus.out_valid}, 32'h0);
    checkValue("rack_req", {31'b0, bus.imem_req}, 32'h0);
`ifdef FETCH_STATS_EN
    checkValue("lit_flushed2", stat_flushed, 32'd4);
`endif
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    applyStimulus(1, 1, 32'h8888_0000, 0, 32'h0, 1);
    checkValue("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 1, 32'h9999_0000, 0, 32'h0, 1);
    checkValue("wrap_addr2", bus.imem_addr, 32'h0);
    checkValue("wrap_npc", bus.out_next_pc, 32'h0);
    checkValue("wrap_ins", bus.out_ins, 32'h9999_0000);

    // Reset in the middle of a request
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkValue("midrst_req", {31'b0, bus.imem_req}, 32'h0);
    checkValue("midrst_valid", {31'b0, bus.out_valid}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit          rst_n_r;
      bit          ack_r;
      bit          redir_r;
      bit          ready_r;
      logic [31:0] rpc_r;
      rst_n_r = ($urandom_range(0, 599) != 0);
      redir_r = ($urandom_range(0, 11) == 0);
      ready_r = ($urandom_range(0, 9) < 7);
      ack_r   = m_req_active && ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) rpc_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rpc_r = $urandom;
      applyStimulus(rst_n_r, ack_r, $urandom, redir_r, rpc_r, ready_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
